// File: rtl/load_store_unit_if.sv
// Request/response/memory bundle of the load/store unit.
// "slave" is the unit's own view; "master" is the execute/writeback/memory side.
interface load_store_unit_if #(
    parameter int XLEN         = 32,
    parameter int LS_SEL_WIDTH = 3
);
    logic                    i_Req_Valid;
    logic                    o_Req_Ready;
    logic [LS_SEL_WIDTH:0]   i_Load_Store_Type;
    logic [XLEN-1:0]         i_Addr;
    logic [XLEN-1:0]         i_Wdata;

    logic                    o_Resp_Valid;
    logic                    i_Resp_Ready;
    logic [XLEN-1:0]         o_Resp_Data;
    logic                    o_Resp_Misaligned;

    logic                    o_Mem_Enable;
    logic                    o_Mem_Write_Enable;
    logic [LS_SEL_WIDTH:0]   o_Mem_Load_Store_Type;
    logic [XLEN-1:0]         o_Mem_Addr;
    logic [XLEN-1:0]         o_Mem_Data;
    logic [XLEN-1:0]         i_Mem_Data;

    modport slave (
        input  i_Req_Valid, i_Load_Store_Type, i_Addr, i_Wdata, i_Resp_Ready, i_Mem_Data,
        output o_Req_Ready, o_Resp_Valid, o_Resp_Data, o_Resp_Misaligned,
        output o_Mem_Enable, o_Mem_Write_Enable, o_Mem_Load_Store_Type, o_Mem_Addr, o_Mem_Data
    );

    modport master (
        output i_Req_Valid, i_Load_Store_Type, i_Addr, i_Wdata, i_Resp_Ready, i_Mem_Data,
        input  o_Req_Ready, o_Resp_Valid, o_Resp_Data, o_Resp_Misaligned,
        input  o_Mem_Enable, o_Mem_Write_Enable, o_Mem_Load_Store_Type, o_Mem_Addr, o_Mem_Data
    );
endinterface

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit: IDLE -> ACCESS/SPLIT -> RESP.
// Define LSU_MISALIGNED_SPLIT_EN to break misaligned accesses into byte accesses.
module load_store_unit #(
    parameter int XLEN         = 32,
    parameter int LS_SEL_WIDTH = 3
) (
    input  logic              i_Clock,
    input  logic              i_Reset_n,
    load_store_unit_if.slave  bus
);
    localparam int LS_W = LS_SEL_WIDTH + 1;

    localparam logic [LS_W-1:0] LOAD_BYTE          = LS_W'(4'b0000);
    localparam logic [LS_W-1:0] LOAD_HALF          = LS_W'(4'b0001);
    localparam logic [LS_W-1:0] LOAD_WORD          = LS_W'(4'b0010);
    localparam logic [LS_W-1:0] LOAD_BYTE_UNSIGNED = LS_W'(4'b0100);
    localparam logic [LS_W-1:0] LOAD_HALF_UNSIGNED = LS_W'(4'b0101);
    localparam logic [LS_W-1:0] STORE_BYTE         = LS_W'(4'b1000);
    localparam logic [LS_W-1:0] STORE_HALF         = LS_W'(4'b1001);
    localparam logic [LS_W-1:0] STORE_WORD         = LS_W'(4'b1010);

    typedef enum logic [1:0] {IDLE, ACCESS, SPLIT, RESP} state_t;

    function automatic logic is_store(input logic [LS_W-1:0] t);
        return (t == STORE_BYTE) || (t == STORE_HALF) || (t == STORE_WORD);
    endfunction

    function automatic logic is_load(input logic [LS_W-1:0] t);
        return (t == LOAD_BYTE) || (t == LOAD_HALF) || (t == LOAD_WORD) ||
               (t == LOAD_BYTE_UNSIGNED) || (t == LOAD_HALF_UNSIGNED);
    endfunction

    function automatic logic misaligned(input logic [LS_W-1:0] t, input logic [1:0] a);
        logic m;
        m = 1'b0;
        case (t)
            LOAD_HALF, LOAD_HALF_UNSIGNED, STORE_HALF: m = a[0];
            LOAD_WORD, STORE_WORD:                     m = (a != 2'b00);
            default:                                   m = 1'b0;
        endcase
        return m;
    endfunction

    // Index of the final byte access when a misaligned access is split up.
    function automatic logic [1:0] split_last(input logic [LS_W-1:0] t);
        return ((t == LOAD_WORD) || (t == STORE_WORD)) ? 2'd3 : 2'd1;
    endfunction

    function automatic logic [XLEN-1:0] extend_load(input logic [LS_W-1:0] t,
                                                    input logic [XLEN-1:0] raw);
        logic [XLEN-1:0] r;
        r = '0;
        case (t)
            LOAD_BYTE:          r = {{(XLEN-8){raw[7]}}, raw[7:0]};
            LOAD_BYTE_UNSIGNED: r = {{(XLEN-8){1'b0}}, raw[7:0]};
            LOAD_HALF:          r = {{(XLEN-16){raw[15]}}, raw[15:0]};
            LOAD_HALF_UNSIGNED: r = {{(XLEN-16){1'b0}}, raw[15:0]};
            LOAD_WORD:          r = raw;
            default:            r = '0;
        endcase
        return r;
    endfunction

    state_t            state_q, state_d;
    logic [1:0]        idx_q, idx_d;
    logic [LS_W-1:0]   type_q, type_d;
    logic [XLEN-1:0]   addr_q, addr_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;
    logic [XLEN-1:0]   raw_q, raw_d;
    logic [XLEN-1:0]   resp_data_q, resp_data_d;
    logic              mis_q, mis_d;

    logic              req_ready_c;
    logic              resp_valid_c;
    logic [XLEN-1:0]   resp_data_c;
    logic              resp_mis_c;
    logic              mem_en_c;
    logic              mem_we_c;
    logic [LS_W-1:0]   mem_type_c;
    logic [XLEN-1:0]   mem_addr_c;
    logic [XLEN-1:0]   mem_data_c;

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        type_d       = type_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        raw_d        = raw_q;
        resp_data_d  = resp_data_q;
        mis_d        = mis_q;
        req_ready_c  = 1'b0;
        resp_valid_c = 1'b0;
        resp_data_c  = '0;
        resp_mis_c   = 1'b0;
        mem_en_c     = 1'b0;
        mem_we_c     = 1'b0;
        mem_type_c   = '0;
        mem_addr_c   = '0;
        mem_data_c   = '0;

        unique case (state_q)
            IDLE: begin
                req_ready_c = 1'b1;
                if (bus.i_Req_Valid) begin
                    type_d      = bus.i_Load_Store_Type;
                    addr_d      = bus.i_Addr;
                    wdata_d     = bus.i_Wdata;
                    idx_d       = 2'd0;
                    raw_d       = '0;
                    resp_data_d = '0;
                    mis_d       = 1'b0;
                    if (!is_load(bus.i_Load_Store_Type) && !is_store(bus.i_Load_Store_Type)) begin
                        state_d = RESP;
                    end else if (misaligned(bus.i_Load_Store_Type, bus.i_Addr[1:0])) begin
`ifdef LSU_MISALIGNED_SPLIT_EN
                        state_d = SPLIT;
`else
                        state_d = RESP;
                        mis_d   = 1'b1;
`endif
                    end else begin
                        state_d = ACCESS;
                    end
                end
            end
            ACCESS: begin
                mem_en_c    = 1'b1;
                mem_we_c    = is_store(type_q);
                mem_type_c  = type_q;
                mem_addr_c  = addr_q;
                mem_data_c  = wdata_q;
                resp_data_d = extend_load(type_q, bus.i_Mem_Data);
                state_d     = RESP;
            end
            SPLIT: begin
                mem_en_c   = 1'b1;
                mem_we_c   = is_store(type_q);
                mem_type_c = is_store(type_q) ? STORE_BYTE : LOAD_BYTE_UNSIGNED;
                mem_addr_c = addr_q + XLEN'(idx_q);
                mem_data_c = {{(XLEN-8){1'b0}}, wdata_q[{idx_q, 3'b000} +: 8]};
                // Bytes land little-endian in raw_d; the last one completes the word.
                raw_d[{idx_q, 3'b000} +: 8] = bus.i_Mem_Data[7:0];
                if (idx_q == split_last(type_q)) begin
                    resp_data_d = extend_load(type_q, raw_d);
                    state_d     = RESP;
                end else begin
                    idx_d = idx_q + 2'd1;
                end
            end
            RESP: begin
                resp_valid_c = 1'b1;
                resp_data_c  = resp_data_q;
                resp_mis_c   = mis_q;
                if (bus.i_Resp_Ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            state_q <= IDLE;
            idx_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_ff @(posedge i_Clock) begin
        type_q      <= type_d;
        addr_q      <= addr_d;
        wdata_q     <= wdata_d;
        raw_q       <= raw_d;
        resp_data_q <= resp_data_d;
        mis_q       <= mis_d;
    end

    // Ready stays low while reset is held, even though the state is already IDLE.
    assign bus.o_Req_Ready           = req_ready_c & i_Reset_n;
    assign bus.o_Resp_Valid          = resp_valid_c;
    assign bus.o_Resp_Data           = resp_data_c;
    assign bus.o_Resp_Misaligned     = resp_mis_c;
    assign bus.o_Mem_Enable          = mem_en_c;
    assign bus.o_Mem_Write_Enable    = mem_we_c;
    assign bus.o_Mem_Load_Store_Type = mem_type_c;
    assign bus.o_Mem_Addr            = mem_addr_c;
    assign bus.o_Mem_Data            = mem_data_c;
endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a transaction-level memory/response model.
module tb_load_store_unit;
    localparam logic [3:0] LB  = 4'b0000;
    localparam logic [3:0] LH  = 4'b0001;
    localparam logic [3:0] LW  = 4'b0010;
    localparam logic [3:0] LBU = 4'b0100;
    localparam logic [3:0] LHU = 4'b0101;
    localparam logic [3:0] SB  = 4'b1000;
    localparam logic [3:0] SH  = 4'b1001;
    localparam logic [3:0] SW  = 4'b1010;

`ifdef LSU_MISALIGNED_SPLIT_EN
    localparam bit SPLIT_EN = 1'b1;
`else
    localparam bit SPLIT_EN = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] a;
        logic        we;
        logic [3:0]  t;
        logic [31:0] d;
    } acc_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    bit   mon_en;

    bit [7:0]    ram     [0:255];
    bit [7:0]    ref_mem [0:255];
    acc_t        exp_acc [$];
    acc_t        got;
    logic [31:0] exp_data;
    logic        exp_mis;
    logic [7:0]  ra;

    load_store_unit_if #(.XLEN(32), .LS_SEL_WIDTH(3)) bus ();

    load_store_unit #(.XLEN(32), .LS_SEL_WIDTH(3)) dut (
        .i_Clock   (clk),
        .i_Reset_n (rst_n),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Byte-addressed memory: combinational word read, sized write on the edge.
    assign ra = bus.o_Mem_Addr[7:0];
    assign bus.i_Mem_Data = {ram[ra + 8'd3], ram[ra + 8'd2], ram[ra + 8'd1], ram[ra]};

    always @(posedge clk) begin
        if (bus.o_Mem_Enable && bus.o_Mem_Write_Enable) begin
            ram[ra] <= bus.o_Mem_Data[7:0];
            if (bus.o_Mem_Load_Store_Type == SH || bus.o_Mem_Load_Store_Type == SW)
                ram[ra + 8'd1] <= bus.o_Mem_Data[15:8];
            if (bus.o_Mem_Load_Store_Type == SW) begin
                ram[ra + 8'd2] <= bus.o_Mem_Data[23:16];
                ram[ra + 8'd3] <= bus.o_Mem_Data[31:24];
            end
        end
    end

    task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit t_misal(input logic [3:0] t, input logic [31:0] a);
        if (t == LH || t == LHU || t == SH) return a[0];
        if (t == LW || t == SW) return (a % 4) != 0;
        return 1'b0;
    endfunction

    function automatic logic [31:0] model_ext(input logic [3:0] t, input logic [31:0] r);
        case (t)
            LB:      return 32'($signed(r[7:0]));
            LH:      return 32'($signed(r[15:0]));
            LBU:     return 32'(r[7:0]);
            LHU:     return 32'(r[15:0]);
            LW:      return r;
            default: return 32'h0;
        endcase
    endfunction

    // Per-cycle compare of memory-side and response-side outputs against the model.
    always @(negedge clk) begin
        if (rst_n && mon_en) begin
            if (bus.o_Mem_Enable) begin
                if (exp_acc.size() == 0) begin
                    check(1'b0, "unexpected_mem_access", bus.o_Mem_Addr, 32'h0);
                end else begin
                    got = exp_acc.pop_front();
                    check(bus.o_Mem_Addr == got.a, "mem_addr", bus.o_Mem_Addr, got.a);
                    check(bus.o_Mem_Write_Enable == got.we, "mem_we", 32'(bus.o_Mem_Write_Enable), 32'(got.we));
                    check(bus.o_Mem_Load_Store_Type == got.t, "mem_type", 32'(bus.o_Mem_Load_Store_Type), 32'(got.t));
                    check(bus.o_Mem_Data == got.d, "mem_data", bus.o_Mem_Data, got.d);
                end
            end else begin
                check(!bus.o_Mem_Write_Enable && bus.o_Mem_Load_Store_Type == 4'h0 &&
                      bus.o_Mem_Addr == 32'h0 && bus.o_Mem_Data == 32'h0,
                      "mem_idle_zero", bus.o_Mem_Addr | bus.o_Mem_Data, 32'h0);
            end
            if (bus.o_Resp_Valid) begin
                check(bus.o_Resp_Data == exp_data, "resp_data", bus.o_Resp_Data, exp_data);
                check(bus.o_Resp_Misaligned == exp_mis, "resp_mis", 32'(bus.o_Resp_Misaligned), 32'(exp_mis));
                check(!bus.o_Req_Ready, "ready_in_resp", 32'(bus.o_Req_Ready), 32'h0);
            end
        end
    end

    task automatic do_req(input logic [3:0] t, input logic [31:0] a, input logic [31:0] wd,
                          input int hold, output logic [31:0] rd, output logic rm);
        bit          ld, st, vld, mis, doit;
        int          k, lat, n, sz;
        logic [31:0] raw;
        ld   = (t == LB || t == LH || t == LW || t == LBU || t == LHU);
        st   = (t == SB || t == SH || t == SW);
        vld  = ld || st;
        mis  = vld && t_misal(t, a);
        k    = (t == LW || t == SW) ? 4 : 2;
        doit = vld && (!mis || SPLIT_EN);
        lat  = !vld ? 1 : (!mis ? 2 : (SPLIT_EN ? k + 1 : 1));
        raw  = {ref_mem[a[7:0] + 8'd3], ref_mem[a[7:0] + 8'd2], ref_mem[a[7:0] + 8'd1], ref_mem[a[7:0]]};
        exp_mis  = mis && !SPLIT_EN;
        exp_data = (doit && ld) ? model_ext(t, raw) : 32'h0;
        if (doit && !mis) begin
            exp_acc.push_back('{a, st, t, wd});
        end else if (doit) begin
            for (int j = 0; j < k; j++)
                exp_acc.push_back('{a + 32'(j), st, (st ? SB : LBU), {24'h0, wd[8*j +: 8]}});
        end
        if (doit && st) begin
            sz = (t == SB) ? 1 : ((t == SH) ? 2 : 4);
            for (int j = 0; j < sz; j++) ref_mem[a[7:0] + 8'(j)] = wd[8*j +: 8];
        end

        @(negedge clk);
        bus.i_Req_Valid       = 1'b1;
        bus.i_Load_Store_Type = t;
        bus.i_Addr            = a;
        bus.i_Wdata           = wd;
        for (int w = 0; w < 10 && !bus.o_Req_Ready; w++) @(negedge clk);
        check(bus.o_Req_Ready, "req_ready_timeout", 32'(bus.o_Req_Ready), 32'h1);
        @(posedge clk);
        #1 bus.i_Req_Valid = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.o_Resp_Valid && n < 20);
        check(bus.o_Resp_Valid, "resp_timeout", 32'(n), 32'(lat));
        check(n == lat, "latency", 32'(n), 32'(lat));
        rd = bus.o_Resp_Data;
        rm = bus.o_Resp_Misaligned;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check(bus.o_Resp_Valid, "hold_valid", 32'(bus.o_Resp_Valid), 32'h1);
            check(bus.o_Resp_Data == rd, "hold_data", bus.o_Resp_Data, rd);
        end
        bus.i_Resp_Ready = 1'b1;
        @(posedge clk);
        #1 bus.i_Resp_Ready = 1'b0;
        @(negedge clk);
        check(bus.o_Req_Ready && !bus.o_Resp_Valid, "back_to_idle", 32'(bus.o_Req_Ready), 32'h1);
        check(exp_acc.size() == 0, "access_count", 32'(exp_acc.size()), 32'h0);
        exp_acc.delete();
    endtask

    task automatic reset_during_split();
        exp_data = 32'h0;
        exp_mis  = !SPLIT_EN;
        if (SPLIT_EN) begin
            exp_acc.push_back('{32'h41, 1'b1, SB, 32'h88});
            exp_acc.push_back('{32'h42, 1'b1, SB, 32'h77});
        end
        @(negedge clk);
        bus.i_Req_Valid       = 1'b1;
        bus.i_Load_Store_Type = SW;
        bus.i_Addr            = 32'h41;
        bus.i_Wdata           = 32'h55667788;
        @(posedge clk);
        #1 bus.i_Req_Valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        for (int c = 0; c < 3; c++) begin
            check(!bus.o_Mem_Enable && !bus.o_Resp_Valid && !bus.o_Req_Ready,
                  "reset_abort_quiet", {29'h0, bus.o_Mem_Enable, bus.o_Resp_Valid, bus.o_Req_Ready}, 32'h0);
            @(negedge clk);
        end
        check(exp_acc.size() == 0, "reset_access_count", 32'(exp_acc.size()), 32'h0);
        exp_acc.delete();
        #1 rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check(bus.o_Req_Ready && !bus.o_Resp_Valid && !bus.o_Mem_Enable,
                  "post_reset_idle", {29'h0, bus.o_Mem_Enable, bus.o_Resp_Valid, bus.o_Req_Ready}, 32'h1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        logic        rm;
        checks = 0;
        errors = 0;
        mon_en = 1'b0;
        rst_n  = 1'b0;
        bus.i_Req_Valid       = 1'b0;
        bus.i_Load_Store_Type = 4'h0;
        bus.i_Addr            = 32'h0;
        bus.i_Wdata           = 32'h0;
        bus.i_Resp_Ready      = 1'b0;

        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check(!bus.o_Req_Ready && !bus.o_Resp_Valid && !bus.o_Mem_Enable && !bus.o_Mem_Write_Enable &&
                  bus.o_Resp_Data == 32'h0 && !bus.o_Resp_Misaligned && bus.o_Mem_Addr == 32'h0,
                  "reset_outputs", {30'h0, bus.o_Req_Ready, bus.o_Mem_Enable}, 32'h0);
        end
        #1 rst_n = 1'b1;
        mon_en = 1'b1;
        @(negedge clk);
        check(bus.o_Req_Ready, "ready_after_reset", 32'(bus.o_Req_Ready), 32'h1);

        do_req(SW, 32'h10, 32'hDEADBEEF, 0, rd, rm);
        check(rd == 32'h0 && !rm, "pin_store_resp", rd, 32'h0);
        do_req(LW, 32'h10, 32'h0, 0, rd, rm);
        check(rd == 32'hDEADBEEF && !rm, "pin_lw_deadbeef", rd, 32'hDEADBEEF);

        do_req(SB, 32'h21, 32'hABCDEF80, 0, rd, rm);
        do_req(LB, 32'h21, 32'h0, 0, rd, rm);
        check(rd == 32'hFFFFFF80 && !rm, "pin_lb_sext", rd, 32'hFFFFFF80);
        do_req(LBU, 32'h21, 32'h0, 0, rd, rm);
        check(rd == 32'h00000080 && !rm, "pin_lbu_zext", rd, 32'h00000080);

        do_req(SB, 32'h14, 32'h000000F0, 0, rd, rm);
        do_req(LH, 32'h13, 32'h0, 0, rd, rm);
`ifdef LSU_MISALIGNED_SPLIT_EN
        check(rd == 32'hFFFFF0DE && !rm, "pin_lh_split", rd, 32'hFFFFF0DE);
`else
        check(rd == 32'h0 && rm, "pin_lh_misaligned", {rd[30:0], rm}, 32'h1);
`endif

        do_req(SW, 32'h31, 32'h11223344, 0, rd, rm);
        do_req(LW, 32'h30, 32'h0, 0, rd, rm);
`ifdef LSU_MISALIGNED_SPLIT_EN
        check(rd == 32'h22334400, "pin_lw_after_split_store", rd, 32'h22334400);
`else
        check(rd == 32'h0, "pin_lw_untouched", rd, 32'h0);
`endif

        do_req(SH, 32'h22, 32'h00008001, 0, rd, rm);
        do_req(LHU, 32'h22, 32'h0, 0, rd, rm);
        check(rd == 32'h00008001, "pin_lhu", rd, 32'h00008001);
        do_req(LH, 32'h22, 32'h0, 0, rd, rm);
        check(rd == 32'hFFFF8001, "pin_lh", rd, 32'hFFFF8001);
        do_req(LW, 32'h20, 32'h0, 5, rd, rm);
        check(rd == 32'h80018000, "pin_lw_hold", rd, 32'h80018000);

        do_req(4'b0011, 32'h10, 32'h0, 0, rd, rm);
        check(rd == 32'h0 && !rm, "pin_invalid_type", {rd[30:0], rm}, 32'h0);
        do_req(4'b1111, 32'h03, 32'h1234, 2, rd, rm);
        check(rd == 32'h0 && !rm, "pin_invalid_misaddr", {rd[30:0], rm}, 32'h0);

        do_req(SH, 32'h51, 32'h0000BEEF, 0, rd, rm);
        do_req(LHU, 32'h51, 32'h0, 0, rd, rm);
        do_req(LW, 32'h52, 32'h0, 3, rd, rm);

        reset_during_split();

        do_req(LW, 32'h10, 32'h0, 0, rd, rm);
        check(rd == 32'hDEADBEEF, "pin_lw_after_reset", rd, 32'hDEADBEEF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, data/address width.
REQ-002 SHALL have port i_Clock  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port i_Reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port i_Req_Valid  input  1  request valid from execute stage.
REQ-005 SHALL have port o_Req_Ready  output  1  unit can accept a request.
REQ-006 SHALL have port i_Load_Store_Type  input  LS_SEL_WIDTH+1  load/store type, encodings from memory.vh.
REQ-007 SHALL have port i_Addr  input  XLEN  byte address.
REQ-008 SHALL have port i_Wdata  input  XLEN  store data, LSB-aligned.
REQ-009 SHALL have port o_Resp_Valid  output  1  response valid to writeback.
REQ-010 SHALL have port i_Resp_Ready  input  1  writeback accepts response.
REQ-011 SHALL have port o_Resp_Data  output  XLEN  load result, extended per type; 0 for stores.
REQ-012 SHALL have port o_Resp_Misaligned  output  1  access was misaligned and not performed.
REQ-013 SHALL have ports o_Mem_Enable, o_Mem_Write_Enable (output 1), o_Mem_Load_Store_Type (output LS_SEL_WIDTH+1), o_Mem_Addr, o_Mem_Data (output XLEN), i_Mem_Data (input XLEN): byte-addressed memory; combinational read, write on clock edge while enabled.

Function
REQ-014 SHALL implement FSM states IDLE, ACCESS, SPLIT, RESP.
REQ-015 o_Req_Ready SHALL be 1 only in IDLE; handshake = i_Req_Valid & o_Req_Ready; on handshake, type/address/data SHALL be registered.
REQ-016 Store = STORE_BYTE/HALF/WORD; load = LOAD_WORD/HALF/HALF_UNSIGNED/BYTE/BYTE_UNSIGNED; any other encoding SHALL go IDLE->RESP with no memory access, data 0, misaligned 0.
REQ-017 Misaligned SHALL mean: half type with addr[0]=1, word type with addr[1:0]!=0; byte accesses never misaligned.
REQ-018 Aligned request: IDLE->ACCESS; ACCESS drives o_Mem_Enable=1 for exactly one cycle with registered type/addr/data, o_Mem_Write_Enable=1 for stores; load data SHALL be captured at end of ACCESS; ACCESS->RESP.
REQ-019 Aligned latency: handshake at cycle N -> o_Resp_Valid=1 at cycle N+2.
REQ-020 In RESP, o_Resp_Valid SHALL be 1 and o_Resp_Data/o_Resp_Misaligned stable until i_Resp_Ready=1; that cycle SHALL return to IDLE.
REQ-021 o_Mem_Enable and o_Mem_Write_Enable SHALL be 0 in IDLE and RESP; o_Mem_Addr/o_Mem_Data/o_Mem_Load_Store_Type SHALL be 0 when o_Mem_Enable=0.
REQ-022 Response data: LOAD_HALF/LOAD_BYTE sign-extended, *_UNSIGNED zero-extended, LOAD_WORD unchanged, stores 0.
REQ-023 Minimum accepted-request spacing SHALL be 3 cycles (IDLE, ACCESS, RESP with immediate i_Resp_Ready).

Reset
REQ-024 While i_Reset_n=0, state SHALL be IDLE and all outputs 0 except o_Req_Ready=1 after reset release only (0 during reset), with no memory write in progress.
REQ-025 Reset asserted mid-operation SHALL abort immediately; no memory enable after assertion; aborted request SHALL produce no response.

Configuration
REQ-026 Macro LSU_MISALIGNED_SPLIT_EN SHALL control misaligned handling.
REQ-027 Without it: misaligned request SHALL go IDLE->RESP, no memory access, o_Resp_Misaligned=1, o_Resp_Data=0.
REQ-028 With it: misaligned request SHALL go IDLE->SPLIT, issuing K byte accesses (K=2 half, 4 word), one per cycle, addr base+k, k=0..K-1 ascending, type STORE_BYTE (data byte k) or LOAD_BYTE_UNSIGNED; bytes assembled little-endian then extended per REQ-022; SPLIT->RESP; o_Resp_Misaligned=0; latency handshake N -> response N+K+1.

Verification
REQ-029 Store word 0xDEADBEEF @0x10, then LOAD_WORD @0x10 -> response 0xDEADBEEF, misaligned 0, response 2 cycles after each handshake.
REQ-030 Store byte 0x80 @0x21; LOAD_BYTE @0x21 -> 0xFFFFFF80; LOAD_BYTE_UNSIGNED @0x21 -> 0x00000080.
REQ-031 LOAD_HALF @0x13: macro off -> misaligned 1, data 0, o_Mem_Enable never 1; macro on -> two byte reads @0x13,0x14, sign-extended result, response 3 cycles after handshake.
REQ-032 Store word 0x11223344 @0x31 with macro on -> four byte writes 0x44,0x33,0x22,0x11 @0x31..0x34; LOAD_WORD @0x30 -> 0x22334400.
REQ-033 Hold i_Resp_Ready=0 for 5 cycles in RESP -> o_Resp_Valid and data stable, o_Req_Ready=0; release -> IDLE next cycle.
REQ-034 Assert i_Reset_n=0 during SPLIT of a word store -> no further o_Mem_Enable, no response, IDLE with o_Req_Ready=1 after release.
